// File: rtl/axi_hdr_insert_arbiter.sv
// ============================================================================
// Module  : axi_hdr_insert_arbiter
// Purpose : Round-robin scheduler sharing one AXI-Stream header-insert engine
//           between NUM_SRC header+payload sources (header, then packet).
// Option  : AXI_HDR_ARB_PKT_CNT_EN adds per-source 16-bit packet counters.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module axi_hdr_insert_arbiter #(
    parameter int DATA_WD      = 32,
    parameter int DATA_BYTE_WD = DATA_WD / 8,
    parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD),
    parameter int NUM_SRC      = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_SRC-1:0]                s_hdr_valid,
    input  logic [NUM_SRC*DATA_WD-1:0]        s_hdr_data,
    input  logic [NUM_SRC*DATA_BYTE_WD-1:0]   s_hdr_keep,
    input  logic [NUM_SRC*BYTE_CNT_WD-1:0]    s_hdr_cnt,
    output logic [NUM_SRC-1:0]                s_hdr_ready,
    input  logic [NUM_SRC-1:0]                s_valid,
    input  logic [NUM_SRC-1:0]                s_last,
    input  logic [NUM_SRC*DATA_WD-1:0]        s_data,
    input  logic [NUM_SRC*DATA_BYTE_WD-1:0]   s_keep,
    output logic [NUM_SRC-1:0]                s_ready,
    output logic                              valid_insert,
    output logic [DATA_WD-1:0]                data_insert,
    output logic [DATA_BYTE_WD-1:0]           keep_insert,
    output logic [BYTE_CNT_WD-1:0]            byte_insert_cnt,
    input  logic                              ready_insert,
    output logic                              valid_in,
    output logic [DATA_WD-1:0]                data_in,
    output logic [DATA_BYTE_WD-1:0]           keep_in,
    output logic                              last_in,
    input  logic                              ready_in,
    output logic [NUM_SRC-1:0]                grant,
    output logic                              busy
`ifdef AXI_HDR_ARB_PKT_CNT_EN
    ,
    output logic [NUM_SRC*16-1:0]             pkt_cnt
`endif
);

    localparam int IDX_WD = $clog2(NUM_SRC);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_HDR  = 2'd1;
    localparam logic [1:0] c_DATA = 2'd2;

    logic [1:0]         state_q, state_d;
    logic [NUM_SRC-1:0] grant_q, grant_d;
    logic [IDX_WD-1:0]  last_grant_q, last_grant_d;

    logic [IDX_WD-1:0]  w_cand;
    logic [IDX_WD-1:0]  w_win_idx;
    logic               w_win_found;
    logic               w_hdr_hs;
    logic               w_last_hs;

    // Round-robin search starting one past the previous owner.
    always_comb begin
        w_cand      = '0;
        w_win_idx   = '0;
        w_win_found = 1'b0;
        for (int k = 1; k <= NUM_SRC; k++) begin
            w_cand = IDX_WD'((int'(last_grant_q) + k) % NUM_SRC);
            if (!w_win_found && s_hdr_valid[w_cand]) begin
                w_win_idx   = w_cand;
                w_win_found = 1'b1;
            end
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= c_IDLE;
            grant_q      <= '0;
            last_grant_q <= IDX_WD'(NUM_SRC - 1);
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        case (state_q)
            c_IDLE: begin
                if (w_win_found) begin
                    state_d      = c_HDR;
                    grant_d      = {{(NUM_SRC-1){1'b0}}, 1'b1} << w_win_idx;
                    last_grant_d = w_win_idx;
                end
            end
            c_HDR: begin
                if (w_hdr_hs) begin
                    state_d = c_DATA;
                end
            end
            c_DATA: begin
                if (w_last_hs) begin
                    state_d = c_IDLE;
                    grant_d = '0;
                end
            end
            default: begin
                state_d = c_IDLE;
                grant_d = '0;
            end
        endcase
    end

    // Output logic: one-hot AND-OR mux, so everything reads 0 while ungranted.
    always_comb begin
        data_insert     = '0;
        keep_insert     = '0;
        byte_insert_cnt = '0;
        data_in         = '0;
        keep_in         = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (grant_q[i]) begin
                data_insert     = s_hdr_data[i*DATA_WD +: DATA_WD];
                keep_insert     = s_hdr_keep[i*DATA_BYTE_WD +: DATA_BYTE_WD];
                byte_insert_cnt = s_hdr_cnt[i*BYTE_CNT_WD +: BYTE_CNT_WD];
                data_in         = s_data[i*DATA_WD +: DATA_WD];
                keep_in         = s_keep[i*DATA_BYTE_WD +: DATA_BYTE_WD];
            end
        end
        last_in      = |(grant_q & s_last);
        valid_insert = (state_q == c_HDR)  && (|(grant_q & s_hdr_valid));
        valid_in     = (state_q == c_DATA) && (|(grant_q & s_valid));
        s_hdr_ready  = (state_q == c_HDR)  ? (grant_q & {NUM_SRC{ready_insert}}) : '0;
        s_ready      = (state_q == c_DATA) ? (grant_q & {NUM_SRC{ready_in}})     : '0;
        grant        = grant_q;
        busy         = (state_q != c_IDLE);
        w_hdr_hs     = valid_insert && ready_insert;
        w_last_hs    = valid_in && ready_in && last_in;
    end

`ifdef AXI_HDR_ARB_PKT_CNT_EN
    logic [NUM_SRC*16-1:0] pkt_cnt_q, pkt_cnt_d;

    always_comb begin
        pkt_cnt_d = pkt_cnt_q;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (w_last_hs && grant_q[i]) begin
                pkt_cnt_d[i*16 +: 16] = pkt_cnt_q[i*16 +: 16] + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pkt_cnt_q <= '0;
        end else begin
            pkt_cnt_q <= pkt_cnt_d;
        end
    end

    assign pkt_cnt = pkt_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_axi_hdr_insert_arbiter.sv
// ============================================================================
// Module  : tb_axi_hdr_insert_arbiter
// Purpose : Directed self-checking bench for axi_hdr_insert_arbiter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_axi_hdr_insert_arbiter;

    localparam int NS = 4;
    localparam int DW = 32;
    localparam int BW = 4;
    localparam int CW = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic [NS-1:0]   s_hdr_valid;
    logic [NS*DW-1:0] s_hdr_data;
    logic [NS*BW-1:0] s_hdr_keep;
    logic [NS*CW-1:0] s_hdr_cnt;
    logic [NS-1:0]   s_hdr_ready;
    logic [NS-1:0]   s_valid;
    logic [NS-1:0]   s_last;
    logic [NS*DW-1:0] s_data;
    logic [NS*BW-1:0] s_keep;
    logic [NS-1:0]   s_ready;
    logic            valid_insert;
    logic [DW-1:0]   data_insert;
    logic [BW-1:0]   keep_insert;
    logic [CW-1:0]   byte_insert_cnt;
    logic            ready_insert;
    logic            valid_in;
    logic [DW-1:0]   data_in;
    logic [BW-1:0]   keep_in;
    logic            last_in;
    logic            ready_in;
    logic [NS-1:0]   grant;
    logic            busy;
`ifdef AXI_HDR_ARB_PKT_CNT_EN
    logic [NS*16-1:0] pkt_cnt;
`endif

    int vecs = 0;
    int errs = 0;

    always #5 clk = ~clk;

    axi_hdr_insert_arbiter #(
        .DATA_WD(DW), .DATA_BYTE_WD(BW), .BYTE_CNT_WD(CW), .NUM_SRC(NS)
    ) dut (
        .clk(clk), .rst(rst),
        .s_hdr_valid(s_hdr_valid), .s_hdr_data(s_hdr_data), .s_hdr_keep(s_hdr_keep),
        .s_hdr_cnt(s_hdr_cnt), .s_hdr_ready(s_hdr_ready),
        .s_valid(s_valid), .s_last(s_last), .s_data(s_data), .s_keep(s_keep),
        .s_ready(s_ready),
        .valid_insert(valid_insert), .data_insert(data_insert), .keep_insert(keep_insert),
        .byte_insert_cnt(byte_insert_cnt), .ready_insert(ready_insert),
        .valid_in(valid_in), .data_in(data_in), .keep_in(keep_in), .last_in(last_in),
        .ready_in(ready_in), .grant(grant), .busy(busy)
`ifdef AXI_HDR_ARB_PKT_CNT_EN
        , .pkt_cnt(pkt_cnt)
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        s_hdr_valid  = '0;
        s_hdr_data   = '0;
        s_hdr_keep   = '0;
        s_hdr_cnt    = '0;
        s_valid      = '0;
        s_last       = '0;
        s_data       = '0;
        s_keep       = '0;
        ready_insert = 1'b1;
        ready_in     = 1'b1;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        s_hdr_valid = 4'b1111;
        s_valid     = 4'b1111;
        s_hdr_data  = {4{32'hDEAD_BEEF}};
        s_data      = {4{32'hCAFE_F00D}};
        s_last      = 4'b1111;
        #1;
        vecs++; if (grant !== 4'b0000) begin errs++; $display("FAIL reset_grant: got %b want 0000", grant); end
        vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL reset_busy: got %b want 0", busy); end
        vecs++; if (valid_insert !== 1'b0 || valid_in !== 1'b0) begin errs++; $display("FAIL reset_valids: got %b/%b want 0/0", valid_insert, valid_in); end
        vecs++; if (s_hdr_ready !== 4'b0 || s_ready !== 4'b0) begin errs++; $display("FAIL reset_readys: got %b/%b want 0/0", s_hdr_ready, s_ready); end
        vecs++; if (data_insert !== 32'h0 || data_in !== 32'h0 || last_in !== 1'b0 || byte_insert_cnt !== 2'd0) begin
            errs++; $display("FAIL reset_data: got %h/%h/%b/%0d want 0", data_insert, data_in, last_in, byte_insert_cnt); end
        clear_inputs();
    endtask

    task automatic test_single_packet();
        s_hdr_valid[0]     = 1'b1;
        s_hdr_data[31:0]   = 32'hA0A0_0001;
        s_hdr_keep[3:0]    = 4'h7;
        s_hdr_cnt[1:0]     = 2'd3;
        #1;
        vecs++; if (grant !== 4'b0000) begin errs++; $display("FAIL single_pre_grant: got %b want 0000", grant); end
        step();
        vecs++; if (grant !== 4'b0001 || valid_insert !== 1'b1 || busy !== 1'b1) begin
            errs++; $display("FAIL single_hdr_grant: got %b/%b/%b want 0001/1/1", grant, valid_insert, busy); end
        vecs++; if (data_insert !== 32'hA0A0_0001 || keep_insert !== 4'h7 || byte_insert_cnt !== 2'd3) begin
            errs++; $display("FAIL single_hdr_data: got %h/%h/%0d want a0a00001/7/3", data_insert, keep_insert, byte_insert_cnt); end
        vecs++; if (s_hdr_ready !== 4'b0001 || s_ready !== 4'b0000) begin
            errs++; $display("FAIL single_hdr_ready: got %b/%b want 0001/0000", s_hdr_ready, s_ready); end
        step();
        s_hdr_valid[0] = 1'b0;
        s_keep[3:0]    = 4'hF;
        for (int b = 0; b < 4; b++) begin
            s_valid[0]     = 1'b1;
            s_data[31:0]   = 32'hD0D0_0000 + 32'(b);
            s_last[0]      = (b == 3);
            #1;
            vecs++; if (valid_in !== 1'b1 || data_in !== 32'hD0D0_0000 + 32'(b) || last_in !== (b == 3) || valid_insert !== 1'b0) begin
                errs++; $display("FAIL single_beat%0d: got v=%b d=%h l=%b vi=%b", b, valid_in, data_in, last_in, valid_insert); end
            vecs++; if (s_ready !== 4'b0001 || keep_in !== 4'hF) begin
                errs++; $display("FAIL single_beat%0d_ready: got %b/%h want 0001/f", b, s_ready, keep_in); end
            step();
        end
        s_valid = '0;
        s_last  = '0;
        #1;
        vecs++; if (grant !== 4'b0000 || busy !== 1'b0 || valid_in !== 1'b0) begin
            errs++; $display("FAIL single_end: got %b/%b/%b want 0000/0/0", grant, busy, valid_in); end
        clear_inputs();
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_g;
        pulse_reset();
        for (int i = 0; i < NS; i++) begin
            s_hdr_data[i*DW +: DW] = 32'h1000_0000 + 32'(i);
            s_data[i*DW +: DW]     = 32'h2000_0000 + 32'(i);
        end
        s_hdr_valid = 4'b1111;
        s_valid     = 4'b1111;
        s_last      = 4'b1111;
        for (int p = 0; p < 5; p++) begin
            exp_g = 4'b0001 << (p % 4);
            step();
            vecs++; if (grant !== exp_g || valid_insert !== 1'b1 || data_insert !== 32'h1000_0000 + 32'(p % 4)) begin
                errs++; $display("FAIL rr_hdr%0d: got %b/%b/%h want %b/1/%h", p, grant, valid_insert, data_insert, exp_g, 32'h1000_0000 + 32'(p % 4)); end
            step();
            vecs++; if (grant !== exp_g || valid_in !== 1'b1 || last_in !== 1'b1 || data_in !== 32'h2000_0000 + 32'(p % 4)) begin
                errs++; $display("FAIL rr_data%0d: got %b/%b/%b/%h want %b/1/1", p, grant, valid_in, last_in, data_in, exp_g); end
            step();
            vecs++; if (grant !== 4'b0000 || busy !== 1'b0) begin
                errs++; $display("FAIL rr_idle%0d: got %b/%b want 0000/0", p, grant, busy); end
        end
        clear_inputs();
    endtask

    task automatic test_payload_first();
        s_valid[2]      = 1'b1;
        s_last[2]       = 1'b1;
        s_data[64 +: 32] = 32'h3333_0002;
        for (int c = 0; c < 3; c++) begin
            #1;
            vecs++; if (s_ready[2] !== 1'b0 || valid_in !== 1'b0) begin
                errs++; $display("FAIL early_idle%0d: got s_ready=%b valid_in=%b want 0/0", c, s_ready[2], valid_in); end
            step();
        end
        s_hdr_valid[2]       = 1'b1;
        s_hdr_data[64 +: 32] = 32'h4444_0002;
        ready_insert         = 1'b0;
        step();
        vecs++; if (grant !== 4'b0100 || s_ready !== 4'b0 || valid_in !== 1'b0 || s_hdr_ready !== 4'b0) begin
            errs++; $display("FAIL early_hdr: got g=%b sr=%b vi=%b hr=%b want 0100/0/0/0", grant, s_ready, valid_in, s_hdr_ready); end
        ready_insert = 1'b1;
        #1;
        vecs++; if (s_hdr_ready !== 4'b0100) begin errs++; $display("FAIL early_hdr_ready: got %b want 0100", s_hdr_ready); end
        step();
        s_hdr_valid[2] = 1'b0;
        #1;
        vecs++; if (valid_in !== 1'b1 || data_in !== 32'h3333_0002 || s_ready !== 4'b0100) begin
            errs++; $display("FAIL early_data: got %b/%h/%b want 1/33330002/0100", valid_in, data_in, s_ready); end
        step();
        clear_inputs();
        #1;
        vecs++; if (grant !== 4'b0000) begin errs++; $display("FAIL early_end: got %b want 0000", grant); end
    endtask

    task automatic test_backpressure();
        int beat;
        s_hdr_valid[3]        = 1'b1;
        s_hdr_data[96 +: 32]  = 32'h5555_0003;
        s_hdr_valid[1]        = 1'b1;
        s_hdr_data[32 +: 32]  = 32'h5555_0001;
        ready_insert          = 1'b0;
        step();
        for (int c = 0; c < 3; c++) begin
            vecs++; if (grant !== 4'b1000 || valid_insert !== 1'b1 || data_insert !== 32'h5555_0003 || s_hdr_ready !== 4'b0) begin
                errs++; $display("FAIL bp_hdr%0d: got g=%b v=%b d=%h r=%b want 1000/1/55550003/0", c, grant, valid_insert, data_insert, s_hdr_ready); end
            step();
        end
        ready_insert = 1'b1;
        step();
        s_hdr_valid[3] = 1'b0;
        beat = 0;
        for (int cyc = 0; cyc < 20 && beat < 6; cyc++) begin
            ready_in             = (cyc % 2 == 0);
            s_valid[3]           = 1'b1;
            s_data[96 +: 32]     = 32'h6600_0000 + 32'(beat);
            s_last[3]            = (beat == 5);
            #1;
            vecs++; if (data_in !== 32'h6600_0000 + 32'(beat) || valid_in !== 1'b1 || grant !== 4'b1000 || busy !== 1'b1) begin
                errs++; $display("FAIL bp_cyc%0d: got d=%h v=%b g=%b b=%b want beat %0d", cyc, data_in, valid_in, grant, busy, beat); end
            vecs++; if (s_ready !== (ready_in ? 4'b1000 : 4'b0000)) begin
                errs++; $display("FAIL bp_ready%0d: got %b ready_in=%b", cyc, s_ready, ready_in); end
            if (ready_in) beat++;
            step();
        end
        s_valid[3] = 1'b0;
        s_last[3]  = 1'b0;
        ready_in   = 1'b1;
        vecs++; if (grant !== 4'b0000 || busy !== 1'b0) begin
            errs++; $display("FAIL bp_end: got %b/%b want 0000/0", grant, busy); end
        step();
        vecs++; if (grant !== 4'b0010 || data_insert !== 32'h5555_0001) begin
            errs++; $display("FAIL bp_next: got %b/%h want 0010/55550001", grant, data_insert); end
        step();
        s_hdr_valid[1] = 1'b0;
        s_valid[1]     = 1'b1;
        s_last[1]      = 1'b1;
        step();
        clear_inputs();
    endtask

    task automatic test_reset_mid_packet();
        s_hdr_valid[0] = 1'b1;
        step();
        vecs++; if (grant !== 4'b0001) begin errs++; $display("FAIL rstmid_grant: got %b want 0001", grant); end
        step();
        s_hdr_valid[0]  = 1'b0;
        s_valid[0]      = 1'b1;
        s_data[31:0]    = 32'h7777_0000;
        step();
        step();
        #1;
        rst            = 1'b1;
        s_hdr_valid[0] = 1'b1;
        s_hdr_valid[2] = 1'b1;
        #1;
        vecs++; if (grant !== 4'b0 || busy !== 1'b0 || valid_in !== 1'b0 || valid_insert !== 1'b0) begin
            errs++; $display("FAIL rstmid_ctl: got g=%b b=%b vi=%b vh=%b want 0", grant, busy, valid_in, valid_insert); end
        vecs++; if (s_ready !== 4'b0 || s_hdr_ready !== 4'b0 || data_in !== 32'h0 || data_insert !== 32'h0) begin
            errs++; $display("FAIL rstmid_data: got %b/%b/%h/%h want 0", s_ready, s_hdr_ready, data_in, data_insert); end
        s_valid = '0;
        step();
        rst = 1'b0;
        step();
        vecs++; if (grant !== 4'b0001) begin errs++; $display("FAIL rstmid_after: got %b want 0001", grant); end
        clear_inputs();
        pulse_reset();
    endtask

`ifdef AXI_HDR_ARB_PKT_CNT_EN
    task automatic send_pkt(input int src);
        s_hdr_valid[src] = 1'b1;
        step();
        step();
        s_hdr_valid[src] = 1'b0;
        s_valid[src]     = 1'b1;
        s_last[src]      = 1'b1;
        step();
        s_valid[src]     = 1'b0;
        s_last[src]      = 1'b0;
    endtask

    task automatic test_pkt_cnt();
        pulse_reset();
        vecs++; if (pkt_cnt !== '0) begin errs++; $display("FAIL cnt_reset: got %h want 0", pkt_cnt); end
        send_pkt(1);
        send_pkt(1);
        send_pkt(1);
        send_pkt(3);
        vecs++; if (pkt_cnt[16 +: 16] !== 16'd3) begin errs++; $display("FAIL cnt_src1: got %0d want 3", pkt_cnt[16 +: 16]); end
        vecs++; if (pkt_cnt[48 +: 16] !== 16'd1) begin errs++; $display("FAIL cnt_src3: got %0d want 1", pkt_cnt[48 +: 16]); end
        vecs++; if (pkt_cnt[0 +: 16] !== 16'd0 || pkt_cnt[32 +: 16] !== 16'd0) begin
            errs++; $display("FAIL cnt_others: got %0d/%0d want 0/0", pkt_cnt[0 +: 16], pkt_cnt[32 +: 16]); end
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        clear_inputs();
        step();
        test_reset();
        step();
        rst = 1'b0;
        step();
        test_single_packet();
        test_round_robin();
        test_payload_first();
        test_backpressure();
        test_reset_mid_packet();
`ifdef AXI_HDR_ARB_PKT_CNT_EN
        test_pkt_cnt();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

`default_nettype wire
